// File: rtl/sd_cmd_pkg.sv
// Shared constants for the SD command master: response types and sizes,
// serialiser status codes and bit positions, controller state codes.
package sd_cmd_pkg;

  localparam int unsigned CMD_W  = 40;
  localparam int unsigned SET_W  = 16;
  localparam int unsigned STAT_W = 16;

  localparam logic [1:0] RSP_NONE  = 2'b00;
  localparam logic [1:0] RSP_SHORT = 2'b01;
  localparam logic [1:0] RSP_LONG  = 2'b10;

  localparam logic [6:0] RSP_SIZE_NONE  = 7'd0;
  localparam logic [6:0] RSP_SIZE_SHORT = 7'd40;
  localparam logic [6:0] RSP_SIZE_LONG  = 7'd127;

  localparam logic [3:0] STAT_WR       = 4'b0001;
  localparam logic [3:0] STAT_WO       = 4'b0010;
  localparam logic [3:0] STAT_DLY_WR   = 4'b0011;
  localparam logic [3:0] STAT_DLY_WO   = 4'b0100;
  localparam logic [3:0] STAT_READ     = 4'b0101;
  localparam logic [3:0] STAT_DLY_READ = 4'b0110;

  localparam int unsigned STAT_CRC_OK_BIT = 5;
  localparam int unsigned STAT_FINAL_BIT  = 6;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_SEND_REQ  = 3'd1;
  localparam state_t ST_WAIT_STAT = 3'd2;
  localparam state_t ST_ACK_STAT  = 3'd3;
  localparam state_t ST_FINISH    = 3'd4;

  // Response length in bits as the serialiser expects it; code 11 behaves as short.
  function automatic logic [6:0] rsp_size(input logic [1:0] rsp_type);
    case (rsp_type)
      RSP_NONE: rsp_size = RSP_SIZE_NONE;
      RSP_LONG: rsp_size = RSP_SIZE_LONG;
      default:  rsp_size = RSP_SIZE_SHORT;
    endcase
  endfunction

endpackage

// File: rtl/sd_cmd_master_ctrl_if.sv
// Controller <-> CMD serialiser signal bundle.
interface sd_cmd_master_ctrl_if;
  logic [sd_cmd_pkg::CMD_W-1:0]  CMD_WORD;
  logic [sd_cmd_pkg::SET_W-1:0]  SETTING_OUT;
  logic                          SER_REQ;
  logic                          SER_ACK;
  logic                          SER_REQ_IN;
  logic                          SER_ACK_IN;
  logic [sd_cmd_pkg::STAT_W-1:0] SER_STATUS;
  logic [sd_cmd_pkg::CMD_W-1:0]  SER_RSP;

  modport master (
    output CMD_WORD, SETTING_OUT, SER_REQ, SER_ACK,
    input  SER_REQ_IN, SER_ACK_IN, SER_STATUS, SER_RSP
  );

  modport slave (
    input  CMD_WORD, SETTING_OUT, SER_REQ, SER_ACK,
    output SER_REQ_IN, SER_ACK_IN, SER_STATUS, SER_RSP
  );
endinterface

// File: rtl/sd_sync2.sv
// Two-flop synchroniser for a single handshake line.
module sd_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  // Shift the raw input through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/sd_cmd_master_ctrl.sv
// SD command-issue controller: packs command/setting words, runs the REQ/ACK
// handshakes with the CMD serialiser and reports completion, CRC error, timeout.
module sd_cmd_master_ctrl
  import sd_cmd_pkg::*;
#(
  parameter int unsigned TMO_W = 16
) (
  input  logic             SD_CLK_IN,
  input  logic             RST_IN_N,
  input  logic             CMD_START,
  input  logic [5:0]       CMD_INDEX,
  input  logic [31:0]      CMD_ARG,
  input  logic [1:0]       RSP_TYPE,
  input  logic             CRC_CHK_EN,
  input  logic             BLK_READ,
  input  logic             BLK_WRITE,
  input  logic [1:0]       WORD_SEL,
  input  logic [TMO_W-1:0] TIMEOUT,
  sd_cmd_master_ctrl_if.master ser,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR_CRC,
  output logic             ERR_TMO,
  output logic [31:0]      RSP_WORD
);

  logic sreq, sack;

  sd_sync2 u_sync_req (.clk(SD_CLK_IN), .rst_n(RST_IN_N), .d(ser.SER_REQ_IN), .q(sreq));
  sd_sync2 u_sync_ack (.clk(SD_CLK_IN), .rst_n(RST_IN_N), .d(ser.SER_ACK_IN), .q(sack));

  state_t             state_q, state_d;
  logic [CMD_W-1:0]   cmd_word_q, cmd_word_d;
  logic [SET_W-1:0]   setting_q, setting_d;
  logic [STAT_W-1:0]  status_q, status_d;
  logic [31:0]        rsp_word_q, rsp_word_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               tmo_en_q, tmo_en_d;
  logic               ser_req_q, ser_req_d;
  logic               ser_ack_q, ser_ack_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_crc_q, err_crc_d;
  logic               err_tmo_q, err_tmo_d;
  logic [6:0]         size_new;

  // Handshake sequencing; the timeout overlay at the end overrides any
  // handshake decision taken on the same edge.
  always_comb begin
    state_d    = state_q;
    cmd_word_d = cmd_word_q;
    setting_d  = setting_q;
    status_d   = status_q;
    rsp_word_d = rsp_word_q;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_en_d   = tmo_en_q;
    ser_req_d  = ser_req_q;
    ser_ack_d  = ser_ack_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_crc_d  = err_crc_q;
    err_tmo_d  = err_tmo_q;
    size_new   = rsp_size(RSP_TYPE);

    case (state_q)
      ST_IDLE: begin
        if (CMD_START) begin
          cmd_word_d = {2'b01, CMD_INDEX, CMD_ARG};
          setting_d  = {1'b0, WORD_SEL, BLK_READ, BLK_WRITE,
                        (size_new == 7'd0) ? 3'd7 : 3'd0, CRC_CHK_EN, size_new};
          err_crc_d  = 1'b0;
          err_tmo_d  = 1'b0;
          tmo_cnt_d  = TIMEOUT;
          tmo_en_d   = |TIMEOUT;
          ser_req_d  = 1'b1;
          busy_d     = 1'b1;
          state_d    = ST_SEND_REQ;
        end
      end
      ST_SEND_REQ: begin
        if (!sack) begin
          ser_req_d = 1'b0;
          state_d   = ST_WAIT_STAT;
        end
      end
      ST_WAIT_STAT: begin
        if (sreq) begin
          status_d  = ser.SER_STATUS;
          ser_ack_d = 1'b1;
          state_d   = ST_ACK_STAT;
        end
      end
      ST_ACK_STAT: begin
        if (status_q[STAT_FINAL_BIT]) begin
          state_d = ST_FINISH;
        end else if (!sreq) begin
          ser_ack_d = 1'b0;
          state_d   = ST_WAIT_STAT;
        end
      end
      ST_FINISH: begin
        if (!sreq || sack) begin
          ser_ack_d  = 1'b0;
          rsp_word_d = ser.SER_RSP[31:0];
          err_crc_d  = setting_q[7] & (|setting_q[6:0]) & ~status_q[STAT_CRC_OK_BIT];
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && tmo_en_q) begin
      tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
      if (tmo_cnt_q == TMO_W'(1)) begin
        ser_req_d  = 1'b0;
        ser_ack_d  = 1'b0;
        rsp_word_d = rsp_word_q;
        err_crc_d  = err_crc_q;
        err_tmo_d  = 1'b1;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
    end
  end

  // Controller state and registered outputs.
  always_ff @(posedge SD_CLK_IN or negedge RST_IN_N) begin
    if (!RST_IN_N) begin
      state_q    <= ST_IDLE;
      cmd_word_q <= '0;
      setting_q  <= '0;
      status_q   <= '0;
      rsp_word_q <= '0;
      tmo_cnt_q  <= '0;
      tmo_en_q   <= 1'b0;
      ser_req_q  <= 1'b0;
      ser_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_crc_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_word_q <= cmd_word_d;
      setting_q  <= setting_d;
      status_q   <= status_d;
      rsp_word_q <= rsp_word_d;
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_en_q   <= tmo_en_d;
      ser_req_q  <= ser_req_d;
      ser_ack_q  <= ser_ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_crc_q  <= err_crc_d;
      err_tmo_q  <= err_tmo_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ser.SER_RSP[39:32], status_q[15:7], status_q[4:0]};

  assign ser.CMD_WORD    = cmd_word_q;
  assign ser.SETTING_OUT = setting_q;
  assign ser.SER_REQ     = ser_req_q;
  assign ser.SER_ACK     = ser_ack_q;
  assign BUSY            = busy_q;
  assign DONE            = done_q;
  assign ERR_CRC         = err_crc_q;
  assign ERR_TMO         = err_tmo_q;
  assign RSP_WORD        = rsp_word_q;

endmodule

// File: tb/tb_sd_cmd_master_ctrl.sv
// Self-checking bench for sd_cmd_master_ctrl with a behavioural serialiser.
module tb_sd_cmd_master_ctrl;
  localparam int unsigned TMO_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic cmd_start;
  logic [5:0] cmd_index;
  logic [31:0] cmd_arg;
  logic [1:0] rsp_type;
  logic crc_chk_en, blk_read, blk_write;
  logic [1:0] word_sel;
  logic [TMO_W-1:0] timeout;
  logic busy, done, err_crc, err_tmo;
  logic [31:0] rsp_word;

  sd_cmd_master_ctrl_if ser_if ();

  sd_cmd_master_ctrl #(.TMO_W(TMO_W)) dut (
    .SD_CLK_IN(clk), .RST_IN_N(rst_n), .CMD_START(cmd_start), .CMD_INDEX(cmd_index),
    .CMD_ARG(cmd_arg), .RSP_TYPE(rsp_type), .CRC_CHK_EN(crc_chk_en), .BLK_READ(blk_read),
    .BLK_WRITE(blk_write), .WORD_SEL(word_sel), .TIMEOUT(timeout), .ser(ser_if.master),
    .BUSY(busy), .DONE(done), .ERR_CRC(err_crc), .ERR_TMO(err_tmo), .RSP_WORD(rsp_word)
  );

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;

  // reference model state
  logic [39:0] exp_cmd;
  logic [15:0] exp_set;
  logic [31:0] exp_rsp = '0;
  int unsigned exp_size;
  int unsigned exp_crc_en;

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected words from the command fields, by plain arithmetic on field weights.
  task automatic model_cmd(input int unsigned idx, input logic [31:0] arg, input int unsigned rt,
                           input int unsigned crc, rd, wr, ws);
    longint unsigned c;
    exp_size   = (rt == 0) ? 0 : (rt == 2) ? 127 : 40;
    exp_crc_en = crc;
    c = 64'h40_0000_0000 + longint'(idx) * 64'h1_0000_0000 + longint'(arg);
    exp_cmd = c[39:0];
    exp_set = 16'(ws * 8192 + rd * 4096 + wr * 2048 + ((exp_size == 0) ? 7 * 256 : 0)
                  + crc * 128 + exp_size);
  endtask

  task automatic do_start(input int unsigned idx, input logic [31:0] arg, input int unsigned rt,
                          input int unsigned crc, rd, wr, ws, tmo);
    model_cmd(idx, arg, rt, crc, rd, wr, ws);
    cmd_index = 6'(idx); cmd_arg = arg; rsp_type = 2'(rt); crc_chk_en = 1'(crc);
    blk_read = 1'(rd); blk_write = 1'(wr); word_sel = 2'(ws); timeout = TMO_W'(tmo);
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    n_checks++; if (ser_if.SER_REQ !== 1'b1) begin n_fail++; $display("FAIL start_req got %b want 1", ser_if.SER_REQ); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy got %b want 1", busy); end
    n_checks++; if (ser_if.CMD_WORD !== exp_cmd) begin n_fail++; $display("FAIL cmd_word got %h want %h", ser_if.CMD_WORD, exp_cmd); end
    n_checks++; if (ser_if.SETTING_OUT !== exp_set) begin n_fail++; $display("FAIL setting got %h want %h", ser_if.SETTING_OUT, exp_set); end
    n_checks++; if ({err_crc, err_tmo} !== 2'b00) begin n_fail++; $display("FAIL start_err_clear got %b want 00", {err_crc, err_tmo}); end
  endtask

  // Serialiser takes the request by dropping its idle ACK.
  task automatic do_accept();
    int n;
    ser_if.SER_ACK_IN = 1'b0;
    n = 0;
    while (ser_if.SER_REQ !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
    n_checks++; if (n != 3) begin n_fail++; $display("FAIL req_fall_latency got %0d want 3", n); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL accept_busy got %b want 1", busy); end
  endtask

  // Serialiser presents one status word; a final one also returns the response.
  task automatic do_status(input logic [15:0] st, input bit fin, input logic [39:0] rsp);
    int n;
    bit exp_err;
    ser_if.SER_STATUS = st;
    ser_if.SER_REQ_IN = 1'b1;
    n = 0;
    while (ser_if.SER_ACK !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    n_checks++; if (n != 3) begin n_fail++; $display("FAIL ack_rise_latency got %0d want 3", n); end
    ser_if.SER_REQ_IN = 1'b0;
    if (!fin) begin
      n = 0;
      while (ser_if.SER_ACK !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
      n_checks++; if (n != 3) begin n_fail++; $display("FAIL ack_fall_latency got %0d want 3", n); end
      n_checks++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL mid_busy_done got %b want 10", {busy, done}); end
    end else begin
      ser_if.SER_RSP = rsp;
      ser_if.SER_ACK_IN = 1'b1;
      exp_rsp = rsp[31:0];
      exp_err = (exp_crc_en != 0) && (exp_size != 0) && (((st >> 5) % 2) == 0);
      n = 0;
      while (done !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      n_checks++; if (n != 3) begin n_fail++; $display("FAIL done_latency got %0d want 3", n); end
      n_checks++; if ({ser_if.SER_ACK, busy} !== 2'b00) begin n_fail++; $display("FAIL done_ack_busy got %b want 00", {ser_if.SER_ACK, busy}); end
      n_checks++; if (rsp_word !== exp_rsp) begin n_fail++; $display("FAIL rsp_word got %h want %h", rsp_word, exp_rsp); end
      n_checks++; if (err_crc !== exp_err) begin n_fail++; $display("FAIL err_crc got %b want %b", err_crc, exp_err); end
      n_checks++; if (err_tmo !== 1'b0) begin n_fail++; $display("FAIL err_tmo got %b want 0", err_tmo); end
      @(posedge clk); #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_width got %b want 0", done); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0; rsp_type = '0;
    crc_chk_en = 1'b0; blk_read = 1'b0; blk_write = 1'b0; word_sel = '0; timeout = '0;
    ser_if.SER_REQ_IN = 1'b0; ser_if.SER_ACK_IN = 1'b1; ser_if.SER_STATUS = '0; ser_if.SER_RSP = '0;
    repeat (3) @(posedge clk);
    #1;
    exp_rsp = '0;
    n_checks++; if (ser_if.CMD_WORD !== 40'h0) begin n_fail++; $display("FAIL rst_cmd_word got %h want 0", ser_if.CMD_WORD); end
    n_checks++; if (ser_if.SETTING_OUT !== 16'h0) begin n_fail++; $display("FAIL rst_setting got %h want 0", ser_if.SETTING_OUT); end
    n_checks++; if (rsp_word !== 32'h0) begin n_fail++; $display("FAIL rst_rsp got %h want 0", rsp_word); end
    n_checks++; if ({ser_if.SER_REQ, ser_if.SER_ACK, busy, done, err_crc, err_tmo} !== 6'b0)
      begin n_fail++; $display("FAIL rst_flags got %b want 000000", {ser_if.SER_REQ, ser_if.SER_ACK, busy, done, err_crc, err_tmo}); end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_cmd0();
    do_start(0, 32'h0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (ser_if.SETTING_OUT !== 16'h0700) begin n_fail++; $display("FAIL cmd0_setting got %h want 0700", ser_if.SETTING_OUT); end
    n_checks++; if (ser_if.CMD_WORD !== 40'h40_0000_0000) begin n_fail++; $display("FAIL cmd0_word got %h want 4000000000", ser_if.CMD_WORD); end
    do_accept();
    do_status(16'h0002, 1'b0, 40'h0);
    do_status(16'h0044, 1'b1, 40'h0);
  endtask

  task automatic test_cmd17();
    do_start(17, 32'h0000_0200, 1, 1, 1, 0, 0, 0);
    n_checks++; if (ser_if.SETTING_OUT !== 16'h10A8) begin n_fail++; $display("FAIL cmd17_setting got %h want 10a8", ser_if.SETTING_OUT); end
    do_accept();
    do_status(16'h0005, 1'b0, 40'h0);
    do_status(16'h0066, 1'b1, 40'h11_0000_0900);
    n_checks++; if (rsp_word !== 32'h0000_0900) begin n_fail++; $display("FAIL cmd17_rsp got %h want 00000900", rsp_word); end
  endtask

  task automatic test_crc_err();
    do_start(17, 32'h0000_0200, 1, 1, 1, 0, 0, 0);
    do_accept();
    do_status(16'h0046, 1'b1, 40'h11_0000_0900);
    n_checks++; if (err_crc !== 1'b1) begin n_fail++; $display("FAIL crc_err_sticky got %b want 1", err_crc); end
  endtask

  task automatic test_timeout();
    int n;
    do_start(9, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 50);
    n = 0;
    while (done !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    n_checks++; if (n != 50) begin n_fail++; $display("FAIL tmo_cycles got %0d want 50", n); end
    n_checks++; if ({ser_if.SER_REQ, ser_if.SER_ACK, busy} !== 3'b000) begin n_fail++; $display("FAIL tmo_lines got %b want 000", {ser_if.SER_REQ, ser_if.SER_ACK, busy}); end
    n_checks++; if (err_tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_flag got %b want 1", err_tmo); end
    n_checks++; if (rsp_word !== exp_rsp) begin n_fail++; $display("FAIL tmo_rsp got %h want %h", rsp_word, exp_rsp); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL tmo_done_width got %b want 0", done); end
    ser_if.SER_ACK_IN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_busy_start();
    int d0;
    d0 = done_cnt;
    do_start(24, 32'h1234_5678, 2, 1, 0, 1, 3, 0);
    do_accept();
    cmd_index = 6'd55; cmd_arg = 32'hFFFF_0000; rsp_type = 2'b00; cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    n_checks++; if (ser_if.CMD_WORD !== exp_cmd) begin n_fail++; $display("FAIL busy_cmd_word got %h want %h", ser_if.CMD_WORD, exp_cmd); end
    n_checks++; if (ser_if.SETTING_OUT !== exp_set) begin n_fail++; $display("FAIL busy_setting got %h want %h", ser_if.SETTING_OUT, exp_set); end
    n_checks++; if ({ser_if.SER_REQ, busy} !== 2'b01) begin n_fail++; $display("FAIL busy_state got %b want 01", {ser_if.SER_REQ, busy}); end
    do_status(16'h0063, 1'b1, 40'hAB_CDEF_0123);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL busy_done_count got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_start(13, 32'h0000_0001, 1, 1, 0, 0, 0, 0);
    do_accept();
    ser_if.SER_STATUS = 16'h0002;
    ser_if.SER_REQ_IN = 1'b1;
    n = 0;
    while (ser_if.SER_ACK !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    n_checks++; if (n != 3) begin n_fail++; $display("FAIL rstmid_ack_rise got %0d want 3", n); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({ser_if.SER_ACK, ser_if.SER_REQ, busy} !== 3'b000) begin n_fail++; $display("FAIL rstmid_lines got %b want 000", {ser_if.SER_ACK, ser_if.SER_REQ, busy}); end
    exp_rsp = '0;
    ser_if.SER_REQ_IN = 1'b0; ser_if.SER_ACK_IN = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    do_start(8, 32'h0000_01AA, 1, 1, 0, 0, 0, 0);
    do_accept();
    do_status(16'h0066, 1'b1, 40'h08_0000_01AA);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int unsigned nst;
      logic [15:0] st;
      logic [39:0] rsp;
      do_start($urandom_range(63), $urandom, $urandom_range(3), $urandom_range(1), $urandom_range(1),
               $urandom_range(1), $urandom_range(3), ($urandom_range(1) == 1) ? 1000 : 0);
      do_accept();
      nst = $urandom_range(3);
      for (int k = 0; k < int'(nst); k++) begin
        st = 16'($urandom_range(1, 6)) | (16'($urandom_range(1)) << 5);
        do_status(st, 1'b0, 40'h0);
      end
      st = 16'($urandom_range(1, 6)) | 16'h0040 | (16'($urandom_range(1)) << 5);
      rsp = {8'($urandom), 32'($urandom)};
      do_status(st, 1'b1, rsp);
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd17();
    test_crc_err();
    test_timeout();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_cmd_master_ctrl.md
# sd_cmd_master_ctrl

Command-issue controller that sits directly upstream of the SD command serialiser, between the host register file and the CMD line engine. Accepts one SD command per request, packs it into the 40-bit command word and 16-bit setting word the serialiser consumes, and runs the two-wire REQ/ACK handshakes in both directions. Collects the serialiser's status and response words and reports completion, CRC error or timeout back to the host side.

## Interface
Parameters:
- TMO_W, 16, width of the timeout counter and TIMEOUT port

Ports:
- SD_CLK_IN  in  1  SD-side clock (same clock as the serialiser)
- RST_IN_N  in  1  reset, asynchronous assert, active-low
- CMD_START  in  1  one-cycle start pulse; ignored while BUSY
- CMD_INDEX  in  6  SD command index
- CMD_ARG  in  32  command argument
- RSP_TYPE  in  2  00 none, 01 short (48-bit), 10 long (136-bit), 11 treated as 01
- CRC_CHK_EN  in  1  check response CRC
- BLK_READ / BLK_WRITE  in  1 each  data-phase hints forwarded in setting word
- WORD_SEL  in  2  which 32-bit word of a long response to return
- TIMEOUT  in  TMO_W  cycle limit; 0 disables timeout
- CMD_WORD  out  40  to serialiser CMD_IN
- SETTING_OUT  out  16  to serialiser SETTING_IN
- SER_REQ  out  1  to serialiser REQ_IN
- SER_ACK  out  1  to serialiser ACK_IN
- SER_REQ_IN  in  1  from serialiser REQ_OUT (status-valid request)
- SER_ACK_IN  in  1  from serialiser ACK_OUT (high = serialiser idle)
- SER_STATUS  in  16  from serialiser STATUS
- SER_RSP  in  40  from serialiser CMD_OUT
- BUSY  out  1  command in flight
- DONE  out  1  one-cycle completion pulse
- ERR_CRC / ERR_TMO  out  1 each  sticky until next CMD_START
- RSP_WORD  out  32  selected response word

## Operation
- SER_REQ_IN and SER_ACK_IN pass through 2-flop synchronisers (sreq, sack); all decisions use synchronised values.
- CMD_START in IDLE latches: CMD_WORD = {2'b01, CMD_INDEX, CMD_ARG}; SETTING_OUT = {1'b0, WORD_SEL, BLK_READ, BLK_WRITE, delay[2:0], CRC_CHK_EN, size[6:0]}; size = 0 / 40 / 127 for none/short/long; delay = 3'd7 when size 0, else 0. Clears ERR_*, loads timeout counter.
- States: IDLE, SEND_REQ, WAIT_STAT, ACK_STAT, FINISH.
- IDLE -> SEND_REQ on CMD_START; SER_REQ=1.
- SEND_REQ: hold SER_REQ until sack==0 (serialiser accepted), then SER_REQ=0 -> WAIT_STAT.
- WAIT_STAT: on sreq==1 capture SER_STATUS into status register, SER_ACK=1 -> ACK_STAT.
- ACK_STAT: if captured status[6]==1 (final) -> FINISH; else hold SER_ACK until sreq==0, then SER_ACK=0 -> WAIT_STAT.
- FINISH: keep SER_ACK=1 until sreq==0 or sack==1; then SER_ACK=0, capture RSP_WORD = SER_RSP[31:0], ERR_CRC = CRC_CHK_EN & (size!=0) & ~status[5], DONE pulse, -> IDLE.
- Timeout: counter decrements every non-IDLE cycle when TIMEOUT!=0; reaching 0 in any non-IDLE state: SER_REQ=SER_ACK=0, ERR_TMO=1, DONE pulse, RSP_WORD unchanged, -> IDLE.
- CMD_START while BUSY: ignored, no state change.

## Timing
- Reset: all outputs 0 (CMD_WORD, SETTING_OUT, RSP_WORD, SER_REQ, SER_ACK, BUSY, DONE, ERR_*), state IDLE, synchronisers 0. Reset mid-command drops SER_REQ/SER_ACK immediately (async).
- CMD_START at edge N -> CMD_WORD/SETTING_OUT valid and SER_REQ=1, BUSY=1 after edge N.
- Raw SER_ACK_IN fall -> SER_REQ fall 3 edges later (2 sync + 1 FSM).
- Raw SER_REQ_IN rise -> SER_ACK rise 3 edges later; status captured on the same edge.
- DONE asserted exactly one cycle, BUSY falls on the same edge DONE rises.
- Timeout takes priority over any handshake event on the same edge.

## Structure
- Shared package sd_cmd_pkg: RSP_TYPE codes, response sizes (0/40/127), status codes (0001 WR, 0010 WO, 0011 DLY_WR, 0100 DLY_WO, 0101 READ, 0110 DLY_READ), status bit positions 5 (CRC valid) and 6 (final), state enum.
- One sub-module: sd_sync2 (2-flop synchroniser, async active-low reset), instanced twice.

## Test plan
- CMD0, arg 0, RSP_TYPE 00 -> SETTING_OUT 16'h0700, CMD_WORD 40'h40_0000_0000; statuses 0010 then 0100|bit6 -> DONE, no errors.
- CMD17 arg 32'h0000_0200, short, CRC on, BLK_READ -> SETTING_OUT 16'h10A8; final status 16'h0066, SER_RSP 40'h11_0000_0900 -> RSP_WORD 32'h0000_0900, ERR_CRC 0.
- Same with final status 16'h0046 -> ERR_CRC 1, DONE pulse.
- TIMEOUT 50, serialiser never acks -> SER_REQ drops, ERR_TMO 1, DONE at cycle 50.
- CMD_START pulsed while BUSY -> CMD_WORD unchanged, single DONE.
- RST_IN_N low during ACK_STAT -> SER_ACK 0 same cycle; new command after release completes normally.
